dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/riscv_pkg.sv | 16 +
 rtl/dmem_arbiter_if.sv | 49 ++++
 rtl/dmem_arbiter.sv | 96 +++++++++
 tb/tb_dmem_arbiter.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared definitions for the data-memory arbiter: bus width defaults and the
// arbiter FSM state encoding.
package riscv_pkg;

    localparam int RV_DATA_W = 32;
    localparam int RV_ADDR_W = 32;

    typedef logic [2:0] arb_state_t;

    localparam arb_state_t ST_IDLE       = 3'd0;
    localparam arb_state_t ST_SERVE_CPU  = 3'd1;
    localparam arb_state_t ST_SERVE_HOST = 3'd2;
    localparam arb_state_t ST_RESP_CPU   = 3'd3;
    localparam arb_state_t ST_RESP_HOST  = 3'd4;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of the core, inventory-host and data-memory signals around the arbiter.
// The slave modport is the arbiter's view; master is the surrounding system.
interface dmem_arbiter_if
    import riscv_pkg::*;
#(
    parameter int DATA_W = RV_DATA_W,
    parameter int ADDR_W = RV_ADDR_W
);

    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_stall;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_rvalid;

    logic              host_req;
    logic              host_we;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wdata;
    logic              host_gnt;
    logic [DATA_W-1:0] host_rdata;
    logic              host_rvalid;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_stall, cpu_rdata, cpu_rvalid,
        input  host_req, host_we, host_addr, host_wdata,
        output host_gnt, host_rdata, host_rvalid,
        output mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_stall, cpu_rdata, cpu_rvalid,
        output host_req, host_we, host_addr, host_wdata,
        input  host_gnt, host_rdata, host_rvalid,
        input  mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: the core normally wins, but the inventory host
// is guaranteed a slot after STARVE_MAX consecutive CPU wins while it waits.
module dmem_arbiter
    import riscv_pkg::*;
#(
    parameter int DATA_W     = RV_DATA_W,
    parameter int ADDR_W     = RV_ADDR_W,
    parameter int STARVE_MAX = 4
)(
    input logic           clk,
    input logic           reset,
    dmem_arbiter_if.slave bus
);

    localparam int                  STREAK_W   = $clog2(STARVE_MAX + 1);
    localparam logic [STREAK_W-1:0] STREAK_CAP = STREAK_W'(STARVE_MAX);

    arb_state_t          r_state;
    logic [STREAK_W-1:0] r_streak;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_cpu_rdata;
    logic [DATA_W-1:0]   r_host_rdata;

    logic w_host_wins;
    logic w_cpu_wins;
    logic w_serve;

    // Host wins when alone, or when contending after the CPU has used up its streak.
    always_comb begin
        w_host_wins = bus.host_req && (!bus.cpu_req || (r_streak == STREAK_CAP));
        w_cpu_wins  = bus.cpu_req && !w_host_wins;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_streak     <= '0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_cpu_rdata  <= '0;
            r_host_rdata <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_cpu_wins) begin
                        r_we    <= bus.cpu_we;
                        r_addr  <= bus.cpu_addr;
                        r_wdata <= bus.cpu_wdata;
                        r_state <= ST_SERVE_CPU;
                        if (!bus.host_req) begin
                            r_streak <= '0;
                        end else if (r_streak != STREAK_CAP) begin
                            r_streak <= r_streak + 1'b1;
                        end
                    end else if (w_host_wins) begin
                        r_we     <= bus.host_we;
                        r_addr   <= bus.host_addr;
                        r_wdata  <= bus.host_wdata;
                        r_state  <= ST_SERVE_HOST;
                        r_streak <= '0;
                    end
                end
                ST_SERVE_CPU: begin
                    if (!r_we) begin
                        r_cpu_rdata <= bus.mem_rdata;
                    end
                    r_state <= ST_RESP_CPU;
                end
                ST_SERVE_HOST: begin
                    if (!r_we) begin
                        r_host_rdata <= bus.mem_rdata;
                    end
                    r_state <= ST_RESP_HOST;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Memory strobes are gated by reset so an abort in SERVE never commits a write.
    assign w_serve       = (r_state == ST_SERVE_CPU) || (r_state == ST_SERVE_HOST);
    assign bus.mem_we    = reset && w_serve && r_we;
    assign bus.mem_addr  = w_serve ? r_addr : '0;
    assign bus.mem_wdata = w_serve ? r_wdata : '0;

    assign bus.cpu_stall   = bus.cpu_req && (r_state != ST_RESP_CPU);
    assign bus.cpu_rvalid  = reset && (r_state == ST_RESP_CPU);
    assign bus.cpu_rdata   = r_cpu_rdata;
    assign bus.host_gnt    = reset && (r_state == ST_SERVE_HOST);
    assign bus.host_rvalid = reset && (r_state == ST_RESP_HOST);
    assign bus.host_rdata  = r_host_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus randomized request traffic
// scored against a transaction-level arbitration and memory model.
module tb_dmem_arbiter;
    import riscv_pkg::*;

    localparam int STARVE_MAX = 4;

    typedef struct packed {
        logic        pend;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    logic clk = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    dmem_arbiter_if #(.DATA_W(32), .ADDR_W(32)) bus ();

    dmem_arbiter #(
        .DATA_W    (32),
        .ADDR_W    (32),
        .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    logic [31:0] tbMem [16];

    assign bus.mem_rdata = tbMem[bus.mem_addr[5:2]];

    always @(posedge clk) begin
        if (bus.mem_we) tbMem[bus.mem_addr[5:2]] = bus.mem_wdata;
    end

    int          compareCount = 0;
    int          mismatchCount = 0;
    logic [31:0] modelMem [16];
    int          modelStreak;
    logic [31:0] modelCpuRdata;
    logic [31:0] modelHostRdata;
    txn_t        cpuTxn;
    txn_t        hostTxn;
    logic        lastHostWon;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus();
        bus.cpu_req    = cpuTxn.pend;
        bus.cpu_we     = cpuTxn.we;
        bus.cpu_addr   = cpuTxn.addr;
        bus.cpu_wdata  = cpuTxn.wdata;
        bus.host_req   = hostTxn.pend;
        bus.host_we    = hostTxn.we;
        bus.host_addr  = hostTxn.addr;
        bus.host_wdata = hostTxn.wdata;
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    function automatic txn_t randomTxn();
        txn_t t;
        t.pend       = 1'b1;
        t.we         = 1'($urandom_range(0, 1));
        t.addr       = $urandom;
        t.addr[1:0]  = 2'b00;
        t.wdata      = $urandom;
        return t;
    endfunction

    task automatic doReset();
        reset = 1'b0;
        cpuTxn.pend = 1'b0;
        hostTxn.pend = 1'b0;
        applyStimulus();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checkOutput("rstRvalid", 64'({bus.cpu_rvalid, bus.host_rvalid}), 64'(0));
            checkOutput("rstGnt", 64'(bus.host_gnt), 64'(0));
            checkOutput("rstMemWe", 64'(bus.mem_we), 64'(0));
            stepCycle();
        end
        @(negedge clk);
        checkOutput("rstCpuRdata", 64'(bus.cpu_rdata), 64'(0));
        checkOutput("rstHostRdata", 64'(bus.host_rdata), 64'(0));
        checkOutput("rstMemAddr", 64'(bus.mem_addr), 64'(0));
        stepCycle();
        reset = 1'b1;
        modelStreak = 0;
        modelCpuRdata = '0;
        modelHostRdata = '0;
    endtask

    // One arbitration round starting in IDLE: decide the winner from the
    // starvation rule, then check the fixed three-cycle access.
    task automatic runRound();
        logic cpuWins;
        txn_t w;
        if (!cpuTxn.pend && !hostTxn.pend) begin
            applyStimulus();
            @(negedge clk);
            checkOutput("quietStall", 64'(bus.cpu_stall), 64'(0));
            checkOutput("quietGnt", 64'(bus.host_gnt), 64'(0));
            checkOutput("quietMemWe", 64'(bus.mem_we), 64'(0));
            stepCycle();
            return;
        end
        cpuWins = cpuTxn.pend && !(hostTxn.pend && modelStreak == STARVE_MAX);
        w = cpuWins ? cpuTxn : hostTxn;
        if (cpuWins) modelStreak = hostTxn.pend ? ((modelStreak < STARVE_MAX) ? modelStreak + 1 : STARVE_MAX) : 0;
        else modelStreak = 0;

        applyStimulus();
        @(negedge clk);
        checkOutput("idleStall", 64'(bus.cpu_stall), 64'(cpuTxn.pend));
        checkOutput("idleGnt", 64'(bus.host_gnt), 64'(0));
        checkOutput("idleMemWe", 64'(bus.mem_we), 64'(0));
        checkOutput("idleRvalid", 64'({bus.cpu_rvalid, bus.host_rvalid}), 64'(0));
        stepCycle();

        @(negedge clk);
        lastHostWon = bus.host_gnt;
        checkOutput("serveGnt", 64'(bus.host_gnt), 64'(!cpuWins));
        checkOutput("serveMemWe", 64'(bus.mem_we), 64'(w.we));
        checkOutput("serveMemAddr", 64'(bus.mem_addr), 64'(w.addr));
        checkOutput("serveMemWdata", 64'(bus.mem_wdata), 64'(w.wdata));
        checkOutput("serveStall", 64'(bus.cpu_stall), 64'(cpuTxn.pend));
        checkOutput("serveRvalid", 64'({bus.cpu_rvalid, bus.host_rvalid}), 64'(0));
        if (w.we) modelMem[w.addr[5:2]] = w.wdata;
        else if (cpuWins) modelCpuRdata = modelMem[w.addr[5:2]];
        else modelHostRdata = modelMem[w.addr[5:2]];
        stepCycle();

        @(negedge clk);
        checkOutput("respCpuValid", 64'(bus.cpu_rvalid), 64'(cpuWins));
        checkOutput("respHostValid", 64'(bus.host_rvalid), 64'(!cpuWins));
        checkOutput("respCpuRdata", 64'(bus.cpu_rdata), 64'(modelCpuRdata));
        checkOutput("respHostRdata", 64'(bus.host_rdata), 64'(modelHostRdata));
        checkOutput("respStall", 64'(bus.cpu_stall), 64'(cpuTxn.pend && !cpuWins));
        checkOutput("respMemWe", 64'(bus.mem_we), 64'(0));
        checkOutput("respMemAddr", 64'(bus.mem_addr), 64'(0));
        stepCycle();
        if (cpuWins) cpuTxn.pend = 1'b0;
        else hostTxn.pend = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [9:0]  starvePattern;
        logic [31:0] keptWord;
        for (int i = 0; i < 16; i++) begin
            tbMem[i] = $urandom;
            modelMem[i] = tbMem[i];
        end
        cpuTxn = '0;
        hostTxn = '0;
        lastHostWon = 1'b0;
        applyStimulus();
        doReset();

        // CPU-only read of a known word.
        tbMem[4] = 32'hDEADBEEF;
        modelMem[4] = 32'hDEADBEEF;
        cpuTxn = '{pend: 1'b1, we: 1'b0, addr: 32'h10, wdata: 32'h0};
        runRound();
        checkOutput("cpuReadWord", 64'(bus.cpu_rdata), 64'(32'hDEADBEEF));

        // Host-only write.
        hostTxn = '{pend: 1'b1, we: 1'b1, addr: 32'h20, wdata: 32'h5};
        runRound();
        checkOutput("hostWriteMem", 64'(tbMem[8]), 64'(32'h5));

        // Both requesting continuously from reset: C,C,C,C,H,C,C,C,C,H.
        doReset();
        starvePattern = 10'b10_0001_0000;
        cpuTxn = '{pend: 1'b1, we: 1'b0, addr: 32'h0, wdata: 32'h0};
        hostTxn = '{pend: 1'b1, we: 1'b0, addr: 32'h4, wdata: 32'h0};
        for (int i = 0; i < 10; i++) begin
            runRound();
            checkOutput($sformatf("starveSeq%0d", i), 64'(lastHostWon), 64'(starvePattern[i]));
            cpuTxn.pend = 1'b1;
            hostTxn.pend = 1'b1;
        end
        cpuTxn.pend = 1'b0;
        hostTxn.pend = 1'b0;
        runRound();

        // Reset asserted while a CPU store is in its memory cycle.
        keptWord = modelMem[3];
        cpuTxn = '{pend: 1'b1, we: 1'b1, addr: 32'h0C, wdata: 32'hA5A5_5A5A};
        applyStimulus();
        @(negedge clk);
        checkOutput("abortIdleStall", 64'(bus.cpu_stall), 64'(1));
        stepCycle();
        reset = 1'b0;
        @(negedge clk);
        checkOutput("abortMemWe", 64'(bus.mem_we), 64'(0));
        stepCycle();
        reset = 1'b1;
        cpuTxn.pend = 1'b0;
        modelStreak = 0;
        modelCpuRdata = '0;
        modelHostRdata = '0;
        applyStimulus();
        @(negedge clk);
        checkOutput("abortRvalid", 64'(bus.cpu_rvalid), 64'(0));
        checkOutput("abortStall", 64'(bus.cpu_stall), 64'(0));
        stepCycle();
        checkOutput("abortMemKept", 64'(tbMem[3]), 64'(keptWord));
        hostTxn = randomTxn();
        hostTxn.we = 1'b0;
        runRound();

        // Host request raised while the CPU is in its response cycle.
        cpuTxn = randomTxn();
        cpuTxn.we = 1'b0;
        modelStreak = 0;
        modelCpuRdata = modelMem[cpuTxn.addr[5:2]];
        applyStimulus();
        stepCycle();
        stepCycle();
        hostTxn = randomTxn();
        hostTxn.we = 1'b0;
        applyStimulus();
        @(negedge clk);
        checkOutput("lateHostGnt", 64'(bus.host_gnt), 64'(0));
        checkOutput("lateCpuValid", 64'(bus.cpu_rvalid), 64'(1));
        checkOutput("lateCpuRdata", 64'(bus.cpu_rdata), 64'(modelCpuRdata));
        stepCycle();
        cpuTxn.pend = 1'b0;
        runRound();

        // Randomized traffic.
        for (int r = 0; r < 300; r++) begin
            if (!cpuTxn.pend && $urandom_range(0, 1) == 1) cpuTxn = randomTxn();
            if (!hostTxn.pend && $urandom_range(0, 1) == 1) hostTxn = randomTxn();
            runRound();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
